uaslr_inst_remap: RTL and testbench
===================================

// Module: uaslr_inst_remap
// PURPOSE
//  Instruction-side micro-ASLR shim with full req/gnt/rvalid handshake. Sits between the core
//  instruction port and the instruction mux. Shifts the core's view of code by a random,
//  aligned, bounded offset R, which is chosen at the first fetch after reset.
//  Answers the boot fetch locally with JAL R and the prefetch slack with NOPs, then translates
//  every fetch: phys = core_addr - R.
// PARAMETERS
//  ADDR_WIDTH   32  instruction address width
//  DATA_WIDTH   32  instruction data width (fixed 32 for RV encodings)
//  RNG_WIDTH    32  entropy input width (must be >= OFFSET_BITS)
//  OFFSET_BITS  12  R < 2**OFFSET_BITS bytes; legal range 3..20 (JAL reach)
//  ALIGN_BITS   2   R is aligned to 2**ALIGN_BITS bytes (2 = word; 1 = RVC)
//  MAX_FILL     8   max NOP-filled fetches before reaching the target; overrun sets fault
// PORTS
//  clk                  in   1           clock
//  rst_n                in   1           async active-low reset
//  aslr_en_i            in   1           sampled with the first request; 0 -> permanent bypass
//  rng_i                in   RNG_WIDTH   entropy, sampled with the first request
//  core_instr_req_i     in   1           core fetch request
//  core_instr_addr_i    in   ADDR_WIDTH  core (virtual) fetch address
//  core_instr_gnt_o     out  1           grant to core
//  core_instr_rvalid_o  out  1           response valid to core
//  core_instr_rdata_o   out  DATA_WIDTH  response data to core
//  mem_instr_req_o      out  1           request to mux
//  mem_instr_addr_o     out  ADDR_WIDTH  physical fetch address
//  mem_instr_gnt_i      in   1           grant from mux
//  mem_instr_rvalid_i   in   1           response valid from mux
//  mem_instr_rdata_i    in   DATA_WIDTH  response data from mux
//  aslr_active_o        out  1           translation live (state ACTIVE)
//  aslr_offset_o        out  ADDR_WIDTH  latched R, zero-extended
//  aslr_fault_o         out  1           sticky: fill overrun or translation underflow
// BEHAVIOUR
//  Reset: state IDLE. B, R, fill_cnt, fault, and all outputs are 0.
//  Offset R = {rng_i[OFFSET_BITS-1:ALIGN_BITS], ALIGN_BITS'b0}. Target T = B + R mod 2**ADDR_WIDTH.
//  IDLE: mem_instr_req_o = 0. On core_instr_req_i:
//    - latch B = core_instr_addr_i and R.
//    - if !aslr_en_i || R == 0: forward this request unmodified, go to BYPASS.
//    - else: gnt_o = 1 in the same cycle (local grant); next cycle rvalid_o = 1 with
//      rdata = JAL x0,+R (imm sign 0, rd 0, opcode 7'h6f); go to FILL.
//  FILL: every core request gets a local grant in the same cycle and rvalid next cycle
//    with rdata 32'h0000_0013 (NOP); mem_instr_req_o stays 0; fill_cnt++.
//    A request with addr == T is not answered locally: forward it with mem_addr = B, go to ACTIVE.
//    fill_cnt == MAX_FILL with no target seen: set fault, go to ACTIVE.
//  ACTIVE: mem_req = core_req, mem_addr = core_addr - R (mod 2**ADDR_WIDTH), gnt/rvalid/rdata
//    pass-through combinationally. If core_addr < R on a request: set fault (address still wraps).
//  BYPASS: full combinational pass-through, no translation. Terminal until reset.
//  Local responses: at most one outstanding; the 1-cycle rvalid latency is fixed. A new request
//    is accepted in the same cycle a local rvalid is returned (back-to-back).
//  The transition cycle into ACTIVE never overlaps a pending local rvalid with a mem rvalid.
//    The first mem rvalid arrives no earlier than 1 cycle after the forwarded grant.
//  ACTIVE and BYPASS are terminal; aslr_active_o = (state == ACTIVE).
//  Reset mid-operation: everything returns to IDLE and a pending local rvalid is dropped.
//  aslr_offset_o holds R from the latch cycle onward (0 in BYPASS when en = 0).
// STRUCTURE
//  uaslr_pkg: state enum {IDLE, FILL, ACTIVE, BYPASS}, JAL_OPCODE = 7'h6f,
//    NOP_INSN = 32'h0000_0013, function jal_encode(offset) -> 32-bit JAL x0 word.
//  No sub-module: the FSM, latches, fill counter, and subtractor fit in one file.
// TESTING
//  T1 Injection, en = 1, OFFSET_BITS = 12, rng = 0x0000_0A3C, first req addr 0x80:
//     gnt same cycle, rvalid next cycle with rdata 0x23D0_006F, mem_req = 0, offset_o = 0xA3C.
//  T2 Fill then activate: requests 0x84 and 0x88 -> local NOP 0x13 each; request 0xABC ->
//     mem_req = 1, mem_addr = 0x80, active_o = 1; then core 0xAC0 -> mem 0x84.
//  T3 Bypass: rng = 0x3 (R = 0) or en = 0 -> first req at 0x80 forwarded with mem_addr 0x80,
//     active_o = 0, and no JAL is ever returned.
//  T4 Fill overrun, MAX_FILL = 8: 8 fetches never reaching T -> fault_o = 1, then ACTIVE
//     translation is applied.
//  T5 Underflow: ACTIVE with R = 0xA3C, core addr 0x10 -> mem_addr 0xFFFF_F5D4, fault_o stays 1.
//  T6 Reset asserted in FILL with rvalid pending -> all outputs 0 next edge; next req redoes T1.

Source files
------------

// File: rtl/uaslr_pkg.sv
// Shared types and constants for the instruction-side micro-ASLR shim.
//   state_e    : shim FSM states
//   JAL_OPCODE : RV32 JAL major opcode
//   NOP_INSN   : canonical RV32 NOP (addi x0, x0, 0)
//   jal_encode : builds "JAL x0, +offset" from a non-negative byte offset
package uaslr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        ACTIVE = 2'd2,
        BYPASS = 2'd3
    } state_e;

    localparam logic [6:0]  JAL_OPCODE = 7'h6f;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

    // J-type immediate scatter: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
    // The offset is always positive and below 2**20, so imm[20] (sign) is 0.
    function automatic logic [31:0] jal_encode(input logic [20:0] offset);
        logic [31:0] w;
        w        = '0;
        w[31]    = 1'b0;
        w[30:21] = offset[10:1];
        w[20]    = offset[11];
        w[19:12] = offset[19:12];
        w[11:7]  = 5'd0;
        w[6:0]   = JAL_OPCODE;
        return w;
    endfunction

endpackage

// File: rtl/uaslr_inst_remap.sv
// Instruction-side micro-ASLR shim between the core fetch port and the
// instruction mux. On the first fetch after reset it latches a random,
// aligned offset R and the boot address B, answers the boot fetch locally
// with "JAL x0,+R", answers the prefetch slack with NOPs, and once the core
// fetches B+R it translates every fetch to phys = core_addr - R.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   aslr_en_i, rng_i           enable and entropy, sampled with first request
//   core_instr_*               core-side req/gnt/rvalid fetch port
//   mem_instr_*                mux-side req/gnt/rvalid fetch port
//   aslr_active_o              translation live
//   aslr_offset_o              latched R (zero-extended)
//   aslr_fault_o               sticky: fill overrun or translation underflow
module uaslr_inst_remap
    import uaslr_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RNG_WIDTH   = 32,
    parameter int OFFSET_BITS = 12,
    parameter int ALIGN_BITS  = 2,
    parameter int MAX_FILL    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  aslr_en_i,
    input  logic [RNG_WIDTH-1:0]  rng_i,
    input  logic                  core_instr_req_i,
    input  logic [ADDR_WIDTH-1:0] core_instr_addr_i,
    output logic                  core_instr_gnt_o,
    output logic                  core_instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] core_instr_rdata_o,
    output logic                  mem_instr_req_o,
    output logic [ADDR_WIDTH-1:0] mem_instr_addr_o,
    input  logic                  mem_instr_gnt_i,
    input  logic                  mem_instr_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_instr_rdata_i,
    output logic                  aslr_active_o,
    output logic [ADDR_WIDTH-1:0] aslr_offset_o,
    output logic                  aslr_fault_o
);

    localparam int CNT_W = $clog2(MAX_FILL + 1);
    localparam logic [OFFSET_BITS-1:0] ALIGN_MASK =
        ~(OFFSET_BITS'((1 << ALIGN_BITS) - 1));

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [ADDR_WIDTH-1:0]  off_q, off_d;
    logic [CNT_W-1:0]       fill_q, fill_d;
    logic                   fault_q, fault_d;
    // One-deep local response slot (JAL / NOP), returned exactly one cycle after grant.
    logic                   lvld_q, lvld_d;
    logic [DATA_WIDTH-1:0]  ldata_q, ldata_d;

    logic [ADDR_WIDTH-1:0]  off_new;
    logic [ADDR_WIDTH-1:0]  target;
    logic                   pass;
    logic                   unused_rng;

    assign unused_rng = ^rng_i;

    always_comb begin
        off_new                = '0;
        off_new[OFFSET_BITS-1:0] = rng_i[OFFSET_BITS-1:0] & ALIGN_MASK;
    end

    assign target = base_q + off_q;
    assign pass   = (state_q == ACTIVE) || (state_q == BYPASS);

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        off_d            = off_q;
        fill_d           = fill_q;
        fault_d          = fault_q;
        lvld_d           = 1'b0;
        ldata_d          = ldata_q;
        core_instr_gnt_o = 1'b0;
        mem_instr_req_o  = 1'b0;
        mem_instr_addr_o = '0;

        case (state_q)
            IDLE: begin
                if (core_instr_req_i) begin
                    base_d = core_instr_addr_i;
                    off_d  = aslr_en_i ? off_new : '0;
                    if (!aslr_en_i || off_new == '0) begin
                        mem_instr_req_o  = 1'b1;
                        mem_instr_addr_o = core_instr_addr_i;
                        core_instr_gnt_o = mem_instr_gnt_i;
                        state_d          = BYPASS;
                    end else begin
                        core_instr_gnt_o = 1'b1;
                        lvld_d           = 1'b1;
                        ldata_d          = jal_encode(off_new[20:0]);
                        state_d          = FILL;
                    end
                end
            end
            FILL: begin
                if (core_instr_req_i) begin
                    if (core_instr_addr_i == target) begin
                        // Core reached the jump target: hand it the real boot word.
                        mem_instr_req_o  = 1'b1;
                        mem_instr_addr_o = base_q;
                        core_instr_gnt_o = mem_instr_gnt_i;
                        state_d          = ACTIVE;
                    end else begin
                        core_instr_gnt_o = 1'b1;
                        lvld_d           = 1'b1;
                        ldata_d          = NOP_INSN;
                        fill_d           = fill_q + 1'b1;
                        if (fill_d == CNT_W'(MAX_FILL)) begin
                            fault_d = 1'b1;
                            state_d = ACTIVE;
                        end
                    end
                end
            end
            ACTIVE: begin
                mem_instr_req_o  = core_instr_req_i;
                mem_instr_addr_o = core_instr_addr_i - off_q;
                core_instr_gnt_o = mem_instr_gnt_i;
                if (core_instr_req_i && (core_instr_addr_i < off_q))
                    fault_d = 1'b1;
            end
            BYPASS: begin
                mem_instr_req_o  = core_instr_req_i;
                mem_instr_addr_o = core_instr_addr_i;
                core_instr_gnt_o = mem_instr_gnt_i;
            end
            default: state_d = IDLE;
        endcase
    end

    // A local response may still be in flight during the first ACTIVE cycle;
    // the mux cannot answer that soon, so the local slot simply takes priority.
    assign core_instr_rvalid_o = lvld_q | (pass & mem_instr_rvalid_i);
    assign core_instr_rdata_o  = lvld_q ? ldata_q :
                                 (pass ? mem_instr_rdata_i : '0);

    assign aslr_active_o = (state_q == ACTIVE);
    assign aslr_offset_o = off_q;
    assign aslr_fault_o  = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            off_q   <= '0;
            fill_q  <= '0;
            fault_q <= 1'b0;
            lvld_q  <= 1'b0;
            ldata_q <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            off_q   <= off_d;
            fill_q  <= fill_d;
            fault_q <= fault_d;
            lvld_q  <= lvld_d;
            ldata_q <= ldata_d;
        end
    end

endmodule

// File: tb/tb_uaslr_inst_remap.sv
// Scoreboard bench for uaslr_inst_remap: fetches push expected rdata,
// a negedge monitor pops and compares on every core rvalid.
module tb_uaslr_inst_remap;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        aslr_en;
    logic [31:0] rng;
    logic        core_req;
    logic [31:0] core_addr;
    logic        core_gnt, core_rvalid;
    logic [31:0] core_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        aslr_active, aslr_fault;
    logic [31:0] aslr_offset;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] expq[$];

    always #5 clk = ~clk;

    uaslr_inst_remap dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .aslr_en_i           (aslr_en),
        .rng_i               (rng),
        .core_instr_req_i    (core_req),
        .core_instr_addr_i   (core_addr),
        .core_instr_gnt_o    (core_gnt),
        .core_instr_rvalid_o (core_rvalid),
        .core_instr_rdata_o  (core_rdata),
        .mem_instr_req_o     (mem_req),
        .mem_instr_addr_o    (mem_addr),
        .mem_instr_gnt_i     (mem_gnt),
        .mem_instr_rvalid_i  (mem_rvalid),
        .mem_instr_rdata_i   (mem_rdata),
        .aslr_active_o       (aslr_active),
        .aslr_offset_o       (aslr_offset),
        .aslr_fault_o        (aslr_fault)
    );

    // Memory model: always grants, answers next cycle with {C0DE, addr[15:0]}.
    assign mem_gnt = mem_req;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
        end else begin
            mem_rvalid <= mem_req & mem_gnt;
            mem_rdata  <= {16'hC0DE, mem_addr[15:0]};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every core rvalid pops one expected word.
    always @(negedge clk) begin
        if (rst_n && core_rvalid) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rvalid: got %h want none", core_rdata);
            end else begin
                chk("rdata", core_rdata, expq.pop_front());
            end
        end
    end

    // One-cycle fetch; checks grant and mux-side request, queues expected data.
    task automatic fetch(input logic [31:0] a, input logic exp_mreq,
                         input logic [31:0] exp_maddr, input logic [31:0] exp_rdata);
        @(negedge clk);
        core_req  = 1'b1;
        core_addr = a;
        #1;
        chk("gnt", {31'd0, core_gnt}, 32'd1);
        chk("mem_req", {31'd0, mem_req}, {31'd0, exp_mreq});
        if (exp_mreq) chk("mem_addr", mem_addr, exp_maddr);
        expq.push_back(exp_rdata);
        @(posedge clk);
        #1;
        core_req = 1'b0;
    endtask

    task automatic chk_zero_outputs();
        chk("rst_gnt",    {31'd0, core_gnt},    32'd0);
        chk("rst_rvalid", {31'd0, core_rvalid}, 32'd0);
        chk("rst_rdata",  core_rdata,           32'd0);
        chk("rst_mreq",   {31'd0, mem_req},     32'd0);
        chk("rst_maddr",  mem_addr,             32'd0);
        chk("rst_active", {31'd0, aslr_active}, 32'd0);
        chk("rst_offset", aslr_offset,          32'd0);
        chk("rst_fault",  {31'd0, aslr_fault},  32'd0);
    endtask

    task automatic do_reset(input logic en, input logic [31:0] r);
        repeat (3) @(posedge clk);   // let outstanding responses drain
        @(negedge clk);
        rst_n    = 1'b0;
        core_req = 1'b0;
        aslr_en  = en;
        rng      = r;
        #1;
        chk_zero_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [31:0] JAL_A3C = 32'h23D0_006F;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    initial begin
        core_req  = 1'b0;
        core_addr = '0;
        aslr_en   = 1'b1;
        rng       = 32'h0000_0A3C;

        // T1 / T2 / T5
        do_reset(1'b1, 32'h0000_0A3C);
        fetch(32'h80, 1'b0, 32'h0, JAL_A3C);
        chk("t1_offset", aslr_offset, 32'hA3C);
        chk("t1_active", {31'd0, aslr_active}, 32'd0);
        fetch(32'h84, 1'b0, 32'h0, NOP);
        fetch(32'h88, 1'b0, 32'h0, NOP);
        fetch(32'hABC, 1'b1, 32'h80, 32'hC0DE_0080);
        chk("t2_active", {31'd0, aslr_active}, 32'd1);
        fetch(32'hAC0, 1'b1, 32'h84, 32'hC0DE_0084);
        chk("t2_fault", {31'd0, aslr_fault}, 32'd0);
        fetch(32'h10, 1'b1, 32'hFFFF_F5D4, 32'hC0DE_F5D4);
        chk("t5_fault", {31'd0, aslr_fault}, 32'd1);

        // T4 fill overrun
        do_reset(1'b1, 32'h0000_0A3C);
        fetch(32'h80, 1'b0, 32'h0, JAL_A3C);
        for (int i = 0; i < 8; i++) begin
            chk("t4_fault_early", {31'd0, aslr_fault}, 32'd0);
            fetch(32'h100 + 32'(i * 4), 1'b0, 32'h0, NOP);
        end
        chk("t4_fault", {31'd0, aslr_fault}, 32'd1);
        chk("t4_active", {31'd0, aslr_active}, 32'd1);
        fetch(32'h1000, 1'b1, 32'h5C4, 32'hC0DE_05C4);
        fetch(32'h10, 1'b1, 32'hFFFF_F5D4, 32'hC0DE_F5D4);
        chk("t5_fault_stays", {31'd0, aslr_fault}, 32'd1);

        // T3 bypass with R = 0
        do_reset(1'b1, 32'h0000_0003);
        fetch(32'h80, 1'b1, 32'h80, 32'hC0DE_0080);
        chk("t3a_active", {31'd0, aslr_active}, 32'd0);
        chk("t3a_offset", aslr_offset, 32'h0);
        fetch(32'h84, 1'b1, 32'h84, 32'hC0DE_0084);

        // T3 bypass with en = 0
        do_reset(1'b0, 32'h0000_0A3C);
        fetch(32'h80, 1'b1, 32'h80, 32'hC0DE_0080);
        chk("t3b_active", {31'd0, aslr_active}, 32'd0);
        chk("t3b_offset", aslr_offset, 32'h0);
        fetch(32'hABC, 1'b1, 32'hABC, 32'hC0DE_0ABC);

        // T6 reset in FILL with a local rvalid pending
        do_reset(1'b1, 32'h0000_0A3C);
        fetch(32'h80, 1'b0, 32'h0, JAL_A3C);
        @(negedge clk);
        core_req  = 1'b1;
        core_addr = 32'h84;
        #1;
        chk("t6_gnt", {31'd0, core_gnt}, 32'd1);
        @(posedge clk);
        #1;
        core_req = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk_zero_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fetch(32'h80, 1'b0, 32'h0, JAL_A3C);
        chk("t6_offset", aslr_offset, 32'hA3C);

        // Drain: every queued response must have been seen.
        for (int i = 0; i < 20 && expq.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
